// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider_pkg: shared types and constants for the sequential divider|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIN   = 3'd2
`ifdef SEQ_DIVIDER_SIGNED_EN
    ,
    PREP  = 3'd3,
    FIXUP = 3'd4
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider_if: Start/Busy/Done handshake and operand/result bus      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Busy, Done, Quotient, Remainder, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider_trial_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_trial_sub: combinational (WIDTH+1)-bit trial subtractor           |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module div_trial_sub
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider: restoring divider, one quotient bit per clock            |
// | Optional: SEQ_DIVIDER_SIGNED_EN selects two's complement operands     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         Reset_n,
  seq_divider_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH);

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam state_t c_first      = PREP;
  localparam state_t c_after_calc = FIXUP;
`else
  localparam state_t c_first      = CALC;
  localparam state_t c_after_calc = FIN;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic [WIDTH:0]     r_rem;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_zero_pend;
  logic               r_done;
  logic               r_dbz;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               r_neg_q;
  logic               r_neg_r;
`endif

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_r_new;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_borrow;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_busy;
  logic               w_unused;

  assign w_div_zero = (bus.Divisor == '0);
  // A divide-by-zero waits one idle cycle before FIN; no new request is taken then.
  assign w_accept   = bus.Start && !r_zero_pend && ((r_state == IDLE) || (r_state == FIN));

  assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial (
    .a      (w_shift),
    .b      ({1'b0, r_divisor}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  assign w_r_new  = w_borrow ? w_shift : w_diff;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  // The restored remainder is always below the divisor, so its top bit is never read.
  assign w_unused = r_rem[WIDTH];

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_zero_pend) begin
          w_next = FIN;
        end else if (w_accept && !w_div_zero) begin
          w_next = c_first;
        end
      end
      FIN: begin
        if (w_accept) begin
          w_next = w_div_zero ? IDLE : c_first;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_next = c_after_calc;
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      PREP:    w_next = CALC;
      FIXUP:   w_next = FIN;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      CALC:    w_busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
      PREP:    w_busy = 1'b1;
      FIXUP:   w_busy = 1'b1;
`endif
      default: w_busy = 1'b0;
    endcase
  end

  assign bus.Busy      = w_busy;
  assign bus.Done      = r_done;
  assign bus.Quotient  = r_quotient;
  assign bus.Remainder = r_remainder;
  assign bus.DivByZero = r_dbz;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q         <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_zero_pend <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_q         <= bus.Dividend;
        r_divisor   <= bus.Divisor;
        r_rem       <= '0;
        r_cnt       <= c_cnt_w'(WIDTH - 1);
        r_zero_pend <= w_div_zero;
        r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        r_neg_q     <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
        r_neg_r     <= bus.Dividend[WIDTH-1];
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (r_zero_pend) begin
              r_zero_pend <= 1'b0;
              r_quotient  <= '1;
              r_remainder <= r_q;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
            end
          end
`ifdef SEQ_DIVIDER_SIGNED_EN
          PREP: begin
            r_q       <= r_q[WIDTH-1] ? -r_q : r_q;
            r_divisor <= r_divisor[WIDTH-1] ? -r_divisor : r_divisor;
          end
          FIXUP: begin
            r_quotient  <= r_neg_q ? -r_q : r_q;
            r_remainder <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            r_done      <= 1'b1;
          end
`endif
          CALC: begin
            r_rem <= w_r_new;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - 1'b1;
`ifndef SEQ_DIVIDER_SIGNED_EN
            if (r_cnt == '0) begin
              r_quotient  <= w_q_next;
              r_remainder <= w_r_new[WIDTH-1:0];
              r_done      <= 1'b1;
            end
`endif
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_divider: directed vector bench for seq_divider                 |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_seq_divider;

  localparam int WIDTH = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int c_lat  = WIDTH + 2;
  localparam int c_nvec = 7;
`else
  localparam int c_lat  = WIDTH;
  localparam int c_nvec = 10;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs [0:c_nvec-1];

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns edges elapsed until Done is seen, and how many of those cycles had Busy high.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (bus.Busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Start    = 1'b1;
    tick();
    bus.Start    = 1'b0;
    bus.Dividend = ~a;
    bus.Divisor  = b ^ 8'h5A;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    int busy_n;
    start_op(v.a, v.b);
    chk({tag, " dbz_clear"}, {31'd0, bus.DivByZero}, 32'd0);
    wait_done(lat, busy_n);
    chk({tag, " latency"}, lat, (v.b == 8'd0) ? 32'd1 : c_lat);
    chk({tag, " busy_cycles"}, busy_n, (v.b == 8'd0) ? 32'd0 : c_lat);
    chk({tag, " quotient"}, {24'd0, bus.Quotient}, {24'd0, v.q});
    chk({tag, " remainder"}, {24'd0, bus.Remainder}, {24'd0, v.r});
    chk({tag, " dbz"}, {31'd0, bus.DivByZero}, {31'd0, v.z});
    tick();
    chk({tag, " done_fall"}, {31'd0, bus.Done}, 32'd0);
    chk({tag, " hold_q"}, {24'd0, bus.Quotient}, {24'd0, v.q});
  endtask

  initial begin
    int lat;
    int busy_n;
    bus.Start    = 1'b0;
    bus.Dividend = 8'd0;
    bus.Divisor  = 8'd0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};
    vecs[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};
    vecs[3] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0};
    vecs[4] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1};
    vecs[5] = '{8'h07, 8'h02, 8'h03, 8'h01, 1'b0};
    vecs[6] = '{8'hF6, 8'h00, 8'hFF, 8'hF6, 1'b1};
`else
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
    vecs[1] = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1};
    vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3,  1'b0};
    vecs[3] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[6] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0};
    vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0};
    vecs[8] = '{8'd100, 8'd9,   8'd11,  8'd1,  1'b0};
    vecs[9] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
`endif

    tick();
    tick();
    chk("reset busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset done", {31'd0, bus.Done}, 32'd0);
    chk("reset quotient", {24'd0, bus.Quotient}, 32'd0);
    chk("reset remainder", {24'd0, bus.Remainder}, 32'd0);
    chk("reset dbz", {31'd0, bus.DivByZero}, 32'd0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < c_nvec; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Request during an operation in flight is dropped.
    start_op(8'd100, 8'd7);
    tick();
    tick();
    bus.Dividend = 8'd9;
    bus.Divisor  = 8'd3;
    bus.Start    = 1'b1;
    tick();
    bus.Start    = 1'b0;
    wait_done(lat, busy_n);
    chk("busy_ignore latency", lat + 3, c_lat);
    chk("busy_ignore quotient", {24'd0, bus.Quotient}, 32'd14);
    chk("busy_ignore remainder", {24'd0, bus.Remainder}, 32'd2);

    // Back-to-back request issued in the Done cycle.
    start_op(8'd9, 8'd3);
    chk("done_start busy", {31'd0, bus.Busy}, 32'd1);
    wait_done(lat, busy_n);
    chk("done_start latency", lat, c_lat);
    chk("done_start quotient", {24'd0, bus.Quotient}, 32'd3);
    chk("done_start remainder", {24'd0, bus.Remainder}, 32'd0);
    tick();

    // Asynchronous reset in the middle of an iteration.
    start_op(8'd100, 8'd7);
    for (int i = 0; i < 4; i++) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst busy", {31'd0, bus.Busy}, 32'd0);
    chk("async_rst done", {31'd0, bus.Done}, 32'd0);
    chk("async_rst quotient", {24'd0, bus.Quotient}, 32'd0);
    chk("async_rst remainder", {24'd0, bus.Remainder}, 32'd0);
    chk("async_rst dbz", {31'd0, bus.DivByZero}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst idle", {31'd0, bus.Busy}, 32'd0);
    run_vec("post_rst", '{8'd100, 8'd9, 8'd11, 8'd1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
